ddr4_cmd_timing_checker: RTL and testbench
==========================================

DDR4_CMD_TIMING_CHECKER -- requirements
Module: ddr4_cmd_timing_checker

Interface
REQ-001 Parameters (name, default, meaning), all in CPU clock ticks: tRP 24 PRE->ACT same bank; tRCD 24 ACT->RD/WR same bank; tCAS 24 RD->read data; tRAS 52 ACT->PRE same bank; tRC 76 ACT->ACT same bank.
REQ-002 Further parameters: tCWD 20 WR->write data; tRTP 12 RD->PRE same bank; tWR 20 write-data end->PRE; tRRD_L 6 / tRRD_S 4 ACT->ACT same/different bank group; tCCD_L 8 / tCCD_S 4 column->column same/different group; tWTR_L 12 / tWTR_S 4 write-data end->RD same/different group; tBURST 4 burst length; TRFC_CK 280 REF->next ACT.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present this cycle.
REQ-006 cmd_op  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 illegal.
REQ-007 cmd_bg  in  2  bank group; cmd_ba  in  2  bank; cmd_row  in  16  row (ACT only).
REQ-008 viol_valid  out  1  registered pulse, offending command seen previous cycle.
REQ-009 viol_code  out  4  violation code (REQ-016); viol_bank  out  4  {bg,ba} of offender.
REQ-010 bank_open  out  16  bit {bg,ba} set while that bank has an open row.
REQ-011 rd_data_valid  out  1  read-data burst window; wr_data_valid  out  1  write-data burst window.
REQ-012 cmd_count  out  32  accepted (non-violating, non-NOP) commands, wraps at 2^32.

Function
REQ-013 Delta(X,Y) = cycles between accepted command X and check of Y; legal if Delta >= parameter. Internal elapsed counters saturate at 255 (never wrap).
REQ-014 Per-bank FSM: IDLE --ACT--> ACTIVE (row latched) --PRE--> IDLE; REF legal only if all 16 banks IDLE.
REQ-015 A command with any violation is dropped: no FSM, counter, data-window or cmd_count update; viol_valid asserted next cycle.
REQ-016 Codes, lowest checked first wins: 1 illegal opcode; 2 ACT to ACTIVE bank; 3 RD/WR/PRE to IDLE bank; 4 REF with any bank open; 5 tRP; 6 tRC; 7 TRFC_CK (ACT after REF); 8 tRRD_L; 9 tRRD_S; 10 tRCD; 11 tCCD_L; 12 tCCD_S; 13 tWTR_L/tWTR_S; 14 tRAS; 15 tRTP or write recovery (PRE < tCWD+tBURST+tWR after last WR to that bank).
REQ-017 tRRD/tCCD measured against most recent accepted ACT/column command in same group (_L) and in any other group (_S).
REQ-018 tWTR measured from write-data end (WR + tCWD + tBURST) to RD; _L same group, _S other group.
REQ-019 Accepted RD at cycle N: rd_data_valid high cycles N+tCAS .. N+tCAS+tBURST-1; accepted WR: wr_data_valid high N+tCWD .. N+tCWD+tBURST-1; implemented as shift pipelines so overlapping bursts OR together.
REQ-020 cmd_valid=0 or cmd_op=NOP: no checks, no update, no violation.
REQ-021 PRE to IDLE bank is code 3 (not a silent no-op).
REQ-022 viol_bank for REF/illegal opcode = {cmd_bg,cmd_ba} as presented.
REQ-023 Latency: violation outputs and bank_open reflect command one cycle after presentation.

Reset
REQ-024 rst high at an edge: all banks IDLE, bank_open=0, viol_valid=0, viol_code=0, viol_bank=0, rd/wr_data_valid=0, data pipelines flushed, cmd_count=0.
REQ-025 Elapsed counters reset to saturated 255 so first commands after reset are timing-legal.
REQ-026 rst mid-burst aborts pending data windows; rst dominates a same-cycle command.

Verification
REQ-027 ACT bg0/ba0 @0, RD same bank @24 -> no violation; rd_data_valid high cycles 48-51; cmd_count=2.
REQ-028 ACT bg0/ba0 @0, RD @23 -> viol_valid @24, code 10, viol_bank 0; RD dropped, no data window.
REQ-029 ACT bg1/ba0 @0, ACT bg1/ba1 @5 -> code 8; ACT bg2/ba0 @4 instead -> accepted; bank_open = bits 4 and 8 set.
REQ-030 ACT b0 @0, WR @24, RD same group other bank (already open) @55 -> code 13; @60 -> accepted; PRE b0 @67 -> code 15, @92 -> accepted.
REQ-031 ACT b0, REF with b0 open -> code 4; PRE then REF accepted; ACT @REF+279 -> code 7, @REF+280 -> accepted.
REQ-032 Reset asserted during rd_data_valid burst -> next cycle all outputs 0; subsequent ACT immediately legal.

Source files
------------

// File: rtl/ddr4_cmd_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module   : ddr4_cmd_timing_checker
//  Purpose  : Tracks DDR4 per-bank state and inter-command timing, flags and
//             drops violating commands, and models read/write data windows.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr4_cmd_timing_checker #(
    parameter int T_RP    = 24,
    parameter int T_RCD   = 24,
    parameter int T_CAS   = 24,
    parameter int T_RAS   = 52,
    parameter int T_RC    = 76,
    parameter int T_CWD   = 20,
    parameter int T_RTP   = 12,
    parameter int T_WR    = 20,
    parameter int T_RRD_L = 6,
    parameter int T_RRD_S = 4,
    parameter int T_CCD_L = 8,
    parameter int T_CCD_S = 4,
    parameter int T_WTR_L = 12,
    parameter int T_WTR_S = 4,
    parameter int T_BURST = 4,
    parameter int TRFC_CK = 280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_bg,
    input  logic [1:0]  cmd_ba,
    input  logic [15:0] cmd_row,
    output logic        viol_valid,
    output logic [3:0]  viol_code,
    output logic [3:0]  viol_bank,
    output logic [15:0] bank_open,
    output logic        rd_data_valid,
    output logic        wr_data_valid,
    output logic [31:0] cmd_count
);

    localparam logic [2:0] c_OP_NOP = 3'd0;
    localparam logic [2:0] c_OP_ACT = 3'd1;
    localparam logic [2:0] c_OP_RD  = 3'd2;
    localparam logic [2:0] c_OP_WR  = 3'd3;
    localparam logic [2:0] c_OP_PRE = 3'd4;
    localparam logic [2:0] c_OP_REF = 3'd5;

    localparam logic [0:0] c_IDLE   = 1'b0;
    localparam logic [0:0] c_ACTIVE = 1'b1;

    localparam logic [7:0] c_CNT_MAX  = 8'hFF;
    localparam logic [7:0] c_RP       = 8'(T_RP);
    localparam logic [7:0] c_RCD      = 8'(T_RCD);
    localparam logic [7:0] c_RAS      = 8'(T_RAS);
    localparam logic [7:0] c_RC       = 8'(T_RC);
    localparam logic [7:0] c_RTP      = 8'(T_RTP);
    localparam logic [7:0] c_RRD_L    = 8'(T_RRD_L);
    localparam logic [7:0] c_RRD_S    = 8'(T_RRD_S);
    localparam logic [7:0] c_CCD_L    = 8'(T_CCD_L);
    localparam logic [7:0] c_CCD_S    = 8'(T_CCD_S);
    localparam logic [7:0] c_WTR_L_GAP = 8'(T_CWD + T_BURST + T_WTR_L);
    localparam logic [7:0] c_WTR_S_GAP = 8'(T_CWD + T_BURST + T_WTR_S);
    localparam logic [7:0] c_WR_GAP    = 8'(T_CWD + T_BURST + T_WR);

    // Refresh recovery exceeds 255 cycles, so its counter is sized to reach it.
    localparam int                 c_REF_W = $clog2(TRFC_CK + 1);
    localparam logic [c_REF_W-1:0] c_RFC   = c_REF_W'(TRFC_CK);
    localparam logic [c_REF_W-1:0] c_REF_ONE = c_REF_W'(1);

    localparam int c_RD_W = T_CAS + T_BURST - 1;
    localparam int c_WR_W = T_CWD + T_BURST - 1;

    logic [15:0]       r_bank_state;
    logic [15:0][15:0] r_open_row;
    logic [15:0][7:0]  r_act_cnt;
    logic [15:0][7:0]  r_pre_cnt;
    logic [15:0][7:0]  r_rd_cnt;
    logic [15:0][7:0]  r_wr_cnt;
    logic [3:0][7:0]   r_grp_act_cnt;
    logic [3:0][7:0]   r_grp_col_cnt;
    logic [3:0][7:0]   r_grp_wr_cnt;
    logic [c_REF_W-1:0] r_ref_cnt;
    logic [c_RD_W-1:0] r_rd_pipe;
    logic [c_WR_W-1:0] r_wr_pipe;
    logic              r_viol_valid;
    logic [3:0]        r_viol_code;
    logic [3:0]        r_viol_bank;
    logic [31:0]       r_cmd_count;

    logic [3:0]  w_bank;
    logic        w_is_cmd;
    logic [3:0]  w_code;
    logic        w_accept;
    logic        w_acc_act;
    logic        w_acc_rd;
    logic        w_acc_wr;
    logic        w_acc_pre;
    logic        w_acc_ref;
    logic        w_oth_act_ok;
    logic        w_oth_col_ok;
    logic        w_oth_wtr_ok;
    logic [15:0] w_bank_open;
    logic        w_unused_row;

    function automatic logic [7:0] f_sat_inc(input logic [7:0] v);
        return (v == c_CNT_MAX) ? v : v + 8'd1;
    endfunction

    assign w_bank   = {cmd_bg, cmd_ba};
    assign w_is_cmd = cmd_valid && (cmd_op != c_OP_NOP);
    // The latched row is held for observability only.
    assign w_unused_row = ^r_open_row;

    always_comb begin
        for (int b = 0; b < 16; b++) begin
            w_bank_open[b] = (r_bank_state[b] == c_ACTIVE);
        end
    end

    always_comb begin
        w_oth_act_ok = 1'b1;
        w_oth_col_ok = 1'b1;
        w_oth_wtr_ok = 1'b1;
        for (int g = 0; g < 4; g++) begin
            if (2'(g) != cmd_bg) begin
                if (r_grp_act_cnt[g] < c_RRD_S)     w_oth_act_ok = 1'b0;
                if (r_grp_col_cnt[g] < c_CCD_S)     w_oth_col_ok = 1'b0;
                if (r_grp_wr_cnt[g]  < c_WTR_S_GAP) w_oth_wtr_ok = 1'b0;
            end
        end
    end

    // Checks are ordered so the lowest applicable code wins.
    always_comb begin
        w_code = 4'd0;
        if (w_is_cmd) begin
            case (cmd_op)
                c_OP_NOP: w_code = 4'd0;
                c_OP_ACT: begin
                    if (r_bank_state[w_bank] == c_ACTIVE)       w_code = 4'd2;
                    else if (r_pre_cnt[w_bank] < c_RP)          w_code = 4'd5;
                    else if (r_act_cnt[w_bank] < c_RC)          w_code = 4'd6;
                    else if (r_ref_cnt < c_RFC)                 w_code = 4'd7;
                    else if (r_grp_act_cnt[cmd_bg] < c_RRD_L)   w_code = 4'd8;
                    else if (!w_oth_act_ok)                     w_code = 4'd9;
                end
                c_OP_RD, c_OP_WR: begin
                    if (r_bank_state[w_bank] == c_IDLE)         w_code = 4'd3;
                    else if (r_act_cnt[w_bank] < c_RCD)         w_code = 4'd10;
                    else if (r_grp_col_cnt[cmd_bg] < c_CCD_L)   w_code = 4'd11;
                    else if (!w_oth_col_ok)                     w_code = 4'd12;
                    else if ((cmd_op == c_OP_RD) &&
                             ((r_grp_wr_cnt[cmd_bg] < c_WTR_L_GAP) || !w_oth_wtr_ok))
                                                                w_code = 4'd13;
                end
                c_OP_PRE: begin
                    if (r_bank_state[w_bank] == c_IDLE)         w_code = 4'd3;
                    else if (r_act_cnt[w_bank] < c_RAS)         w_code = 4'd14;
                    else if ((r_rd_cnt[w_bank] < c_RTP) ||
                             (r_wr_cnt[w_bank] < c_WR_GAP))     w_code = 4'd15;
                end
                c_OP_REF: begin
                    if (w_bank_open != 16'd0)                   w_code = 4'd4;
                end
                default: w_code = 4'd1;
            endcase
        end
    end

    assign w_accept  = w_is_cmd && (w_code == 4'd0);
    assign w_acc_act = w_accept && (cmd_op == c_OP_ACT);
    assign w_acc_rd  = w_accept && (cmd_op == c_OP_RD);
    assign w_acc_wr  = w_accept && (cmd_op == c_OP_WR);
    assign w_acc_pre = w_accept && (cmd_op == c_OP_PRE);
    assign w_acc_ref = w_accept && (cmd_op == c_OP_REF);

    // Counters load 1 on an event so that in cycle N+k they read k.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_state  <= {16{c_IDLE}};
            r_act_cnt     <= {16{c_CNT_MAX}};
            r_pre_cnt     <= {16{c_CNT_MAX}};
            r_rd_cnt      <= {16{c_CNT_MAX}};
            r_wr_cnt      <= {16{c_CNT_MAX}};
            r_grp_act_cnt <= {4{c_CNT_MAX}};
            r_grp_col_cnt <= {4{c_CNT_MAX}};
            r_grp_wr_cnt  <= {4{c_CNT_MAX}};
            r_ref_cnt     <= c_RFC;
            r_rd_pipe     <= '0;
            r_wr_pipe     <= '0;
            r_viol_valid  <= 1'b0;
            r_viol_code   <= 4'd0;
            r_viol_bank   <= 4'd0;
            r_cmd_count   <= 32'd0;
        end else begin
            for (int b = 0; b < 16; b++) begin
                r_act_cnt[b] <= (w_acc_act && w_bank == 4'(b)) ? 8'd1 : f_sat_inc(r_act_cnt[b]);
                r_pre_cnt[b] <= (w_acc_pre && w_bank == 4'(b)) ? 8'd1 : f_sat_inc(r_pre_cnt[b]);
                r_rd_cnt[b]  <= (w_acc_rd  && w_bank == 4'(b)) ? 8'd1 : f_sat_inc(r_rd_cnt[b]);
                r_wr_cnt[b]  <= (w_acc_wr  && w_bank == 4'(b)) ? 8'd1 : f_sat_inc(r_wr_cnt[b]);
                if (w_acc_act && w_bank == 4'(b)) begin
                    r_bank_state[b] <= c_ACTIVE;
                    r_open_row[b]   <= cmd_row;
                end else if (w_acc_pre && w_bank == 4'(b)) begin
                    r_bank_state[b] <= c_IDLE;
                end
            end
            for (int g = 0; g < 4; g++) begin
                r_grp_act_cnt[g] <= (w_acc_act && cmd_bg == 2'(g)) ? 8'd1
                                    : f_sat_inc(r_grp_act_cnt[g]);
                r_grp_col_cnt[g] <= ((w_acc_rd || w_acc_wr) && cmd_bg == 2'(g)) ? 8'd1
                                    : f_sat_inc(r_grp_col_cnt[g]);
                r_grp_wr_cnt[g]  <= (w_acc_wr && cmd_bg == 2'(g)) ? 8'd1
                                    : f_sat_inc(r_grp_wr_cnt[g]);
            end
            if (w_acc_ref)               r_ref_cnt <= c_REF_ONE;
            else if (r_ref_cnt != c_RFC) r_ref_cnt <= r_ref_cnt + c_REF_ONE;
            r_rd_pipe    <= {r_rd_pipe[c_RD_W-2:0], w_acc_rd};
            r_wr_pipe    <= {r_wr_pipe[c_WR_W-2:0], w_acc_wr};
            r_viol_valid <= (w_code != 4'd0);
            r_viol_code  <= w_code;
            r_viol_bank  <= (w_code != 4'd0) ? w_bank : 4'd0;
            r_cmd_count  <= r_cmd_count + 32'(w_accept);
        end
    end

    assign viol_valid    = r_viol_valid;
    assign viol_code     = r_viol_code;
    assign viol_bank     = r_viol_bank;
    assign bank_open     = w_bank_open;
    assign rd_data_valid = |r_rd_pipe[c_RD_W-1:T_CAS-1];
    assign wr_data_valid = |r_wr_pipe[c_WR_W-1:T_CWD-1];
    assign cmd_count     = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_ddr4_cmd_timing_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr4_cmd_timing_checker
//  Purpose  : Directed and random stimulus against a timestamp-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr4_cmd_timing_checker;

    localparam int T_RP = 24, T_RCD = 24, T_CAS = 24, T_RAS = 52, T_RC = 76;
    localparam int T_CWD = 20, T_RTP = 12, T_WR = 20, T_RRD_L = 6, T_RRD_S = 4;
    localparam int T_CCD_L = 8, T_CCD_S = 4, T_WTR_L = 12, T_WTR_S = 4;
    localparam int T_BURST = 4, TRFC_CK = 280;
    localparam int NEG = -100000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic        viol_valid;
    logic [3:0]  viol_code;
    logic [3:0]  viol_bank;
    logic [15:0] bank_open;
    logic        rd_data_valid;
    logic        wr_data_valid;
    logic [31:0] cmd_count;

    always #5 clk = ~clk;

    ddr4_cmd_timing_checker dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_row(cmd_row),
        .viol_valid(viol_valid), .viol_code(viol_code), .viol_bank(viol_bank),
        .bank_open(bank_open), .rd_data_valid(rd_data_valid),
        .wr_data_valid(wr_data_valid), .cmd_count(cmd_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model: cycle timestamps of the latest accepted event per bank.
    bit          m_open[16];
    int          t_act[16], t_pre[16], t_rd[16], t_wr[16];
    int          t_ref;
    int          rd_q[$], wr_q[$];
    logic [31:0] m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            m_open[k] = 0; t_act[k] = NEG; t_pre[k] = NEG; t_rd[k] = NEG; t_wr[k] = NEG;
        end
        t_ref = NEG;
        rd_q.delete();
        wr_q.delete();
        m_count = 0;
    endtask

    function automatic int model_code(input int op, input int bg, input int ba, input int n);
        int b;
        b = bg * 4 + ba;
        if (op > 5) return 1;
        if (op == 1) begin
            if (m_open[b]) return 2;
            if (n - t_pre[b] < T_RP) return 5;
            if (n - t_act[b] < T_RC) return 6;
            if (n - t_ref < TRFC_CK) return 7;
            for (int k = 0; k < 16; k++) if (k / 4 == bg && n - t_act[k] < T_RRD_L) return 8;
            for (int k = 0; k < 16; k++) if (k / 4 != bg && n - t_act[k] < T_RRD_S) return 9;
            return 0;
        end
        if (op == 2 || op == 3) begin
            if (!m_open[b]) return 3;
            if (n - t_act[b] < T_RCD) return 10;
            for (int k = 0; k < 16; k++)
                if (k / 4 == bg && (n - t_rd[k] < T_CCD_L || n - t_wr[k] < T_CCD_L)) return 11;
            for (int k = 0; k < 16; k++)
                if (k / 4 != bg && (n - t_rd[k] < T_CCD_S || n - t_wr[k] < T_CCD_S)) return 12;
            if (op == 2)
                for (int k = 0; k < 16; k++)
                    if (n - (t_wr[k] + T_CWD + T_BURST) < ((k / 4 == bg) ? T_WTR_L : T_WTR_S))
                        return 13;
            return 0;
        end
        if (op == 4) begin
            if (!m_open[b]) return 3;
            if (n - t_act[b] < T_RAS) return 14;
            if (n - t_rd[b] < T_RTP || n - t_wr[b] < T_CWD + T_BURST + T_WR) return 15;
            return 0;
        end
        for (int k = 0; k < 16; k++) if (m_open[k]) return 4;
        return 0;
    endfunction

    function automatic bit in_window(input int q[$], input int lat, input int m);
        foreach (q[i]) if (q[i] + lat <= m && m <= q[i] + lat + T_BURST - 1) return 1;
        return 0;
    endfunction

    // One cycle: present a command, update the model, check every output.
    task automatic step(input bit r, input bit v, input int op, input int bg,
                        input int ba, input int exp_code);
        int          code;
        int          b;
        logic [15:0] eo;
        @(negedge clk);
        rst = r; cmd_valid = v; cmd_op = 3'(op); cmd_bg = 2'(bg); cmd_ba = 2'(ba);
        cmd_row = 16'($urandom);
        b = bg * 4 + ba;
        code = 0;
        if (r) model_reset();
        else if (v && op != 0) begin
            code = model_code(op, bg, ba, cyc);
            if (code == 0) begin
                case (op)
                    1: begin m_open[b] = 1; t_act[b] = cyc; end
                    2: begin t_rd[b] = cyc; rd_q.push_back(cyc); end
                    3: begin t_wr[b] = cyc; wr_q.push_back(cyc); end
                    4: begin m_open[b] = 0; t_pre[b] = cyc; end
                    default: t_ref = cyc;
                endcase
                m_count = m_count + 1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 16; k++) eo[k] = m_open[k];
        check("viol_valid", viol_valid, code != 0);
        check("viol_code", viol_valid ? viol_code : 4'd0, code);
        check("viol_bank", viol_valid ? viol_bank : 4'd0, (code != 0) ? b : 0);
        check("bank_open", bank_open, eo);
        check("rd_data_valid", rd_data_valid, in_window(rd_q, T_CAS, cyc));
        check("wr_data_valid", wr_data_valid, in_window(wr_q, T_CWD, cyc));
        check("cmd_count", cmd_count, m_count);
        if (exp_code >= 0) check("spec_code", viol_valid ? viol_code : 4'd0, exp_code);
    endtask

    task automatic nop_until(input int t0, input int rel);
        while (cyc < t0 + rel) step(0, 0, 0, 0, 0, -1);
    endtask

    task automatic cmd_at(input int t0, input int rel, input int op, input int bg,
                          input int ba, input int exp_code);
        nop_until(t0, rel);
        step(0, 1, op, bg, ba, exp_code);
    endtask

    // Reset with a competing ACT in the same cycle; reset must win.
    task automatic do_reset();
        step(1, 1, 1, 1, 1, -1);
    endtask

    initial begin
        int t0;
        int x;
        int op;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_bg = 2'd0; cmd_ba = 2'd0;
        cmd_row = 16'd0;
        model_reset();

        // Activate then read at exactly tRCD; data window 48..51.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        cmd_at(t0, 24, 2, 0, 0, 0);
        nop_until(t0, 47);
        check("rd_window_start", rd_data_valid, 1'b0);
        nop_until(t0, 48);
        check("rd_window_on", rd_data_valid, 1'b1);
        nop_until(t0, 53);
        check("cmd_count_two", cmd_count, 32'd2);

        // Read one cycle before tRCD.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        cmd_at(t0, 23, 2, 0, 0, 10);
        check("viol_bank_rcd", viol_bank, 4'd0);
        nop_until(t0, 60);

        // tRRD_L violation, then a legal tRRD_S pair.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 1, 0, 0);
        cmd_at(t0, 5, 1, 1, 1, 8);
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 1, 0, 0);
        cmd_at(t0, 4, 1, 2, 0, 0);
        check("bank_open_pair", bank_open, 16'h0110);

        // Write-to-read and write recovery.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        cmd_at(t0, 6, 1, 0, 1, 0);
        cmd_at(t0, 24, 3, 0, 0, 0);
        cmd_at(t0, 55, 2, 0, 1, 13);
        cmd_at(t0, 60, 2, 0, 1, 0);
        cmd_at(t0, 67, 4, 0, 0, 15);
        cmd_at(t0, 92, 4, 0, 0, 0);

        // Refresh with an open bank, then refresh recovery.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        cmd_at(t0, 1, 5, 0, 0, 4);
        cmd_at(t0, 52, 4, 0, 0, 0);
        cmd_at(t0, 53, 5, 0, 0, 0);
        cmd_at(t0, 53 + 279, 1, 0, 0, 7);
        cmd_at(t0, 53 + 280, 1, 0, 0, 0);

        // Reset in the middle of a read burst.
        do_reset();
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        cmd_at(t0, 24, 2, 0, 0, 0);
        nop_until(t0, 50);
        check("rd_mid_burst", rd_data_valid, 1'b1);
        do_reset();
        check("rst_rd_valid", rd_data_valid, 1'b0);
        check("rst_bank_open", bank_open, 16'd0);
        check("rst_viol_valid", viol_valid, 1'b0);
        check("rst_cmd_count", cmd_count, 32'd0);
        t0 = cyc;
        cmd_at(t0, 0, 1, 0, 0, 0);
        nop_until(t0, 8);

        // Random traffic over two bank groups.
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            x = int'($urandom_range(0, 99));
            op = (x < 30) ? 1 : (x < 50) ? 2 : (x < 70) ? 3 : (x < 90) ? 4 :
                 (x < 93) ? 5 : (x < 97) ? 0 : 6 + (x % 2);
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 9) != 0), op,
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
